sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 40 ++++
 rtl/sram_arbiter_slot_timer.sv | 36 +++
 rtl/sram_arbiter.sv | 118 +++++++++++
 tb/tb_sram_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types and slot-phase constants for the SRAM arbiter.
// The 8-clock frame gives phases 0-3 to video and 4-7 to the CPU.
package sram_arbiter_pkg;

  typedef logic [2:0] phase_t;

  typedef enum logic [1:0] {
    StIdle,
    StVidRd,
    StCpuRd,
    StCpuWr
  } arb_state_e;

  typedef enum logic [1:0] {
    OpNone,
    OpRead,
    OpWrite
  } cpu_op_e;

  localparam phase_t VID_START = 3'd0;
  localparam phase_t VID_LATCH = 3'd2;
  localparam phase_t CEN_PH    = 3'd3;
  localparam phase_t CPU_START = 3'd4;
  localparam phase_t WE_PH     = 3'd5;
  localparam phase_t CPU_LATCH = 3'd6;
  localparam phase_t CEP_PH    = 3'd7;

  function automatic phase_t phase_inc(phase_t p);
    return p + 3'd1;
  endfunction

  // Strobes are active low; both strobes low at once is treated as no access.
  function automatic cpu_op_e cpu_decode(logic mreq_n, logic rd_n, logic wr_n);
    if (mreq_n) return OpNone;
    if (!rd_n && wr_n) return OpRead;
    if (!wr_n && rd_n) return OpWrite;
    return OpNone;
  endfunction

endpackage

// File: rtl/sram_arbiter_slot_timer.sv
// Free-running 3-bit frame phase counter with registered CPU clock-enable pulses.
// cen/cep are registered from the next phase so they line up with ph itself.
module slot_timer
  import sram_arbiter_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  output phase_t ph_o,
  output phase_t ph_next_o,
  output logic   cep_o,
  output logic   cen_o
);

  phase_t ph_q;
  logic   cep_q;
  logic   cen_q;

  assign ph_next_o = phase_inc(ph_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      ph_q  <= VID_START;
      cep_q <= 1'b0;
      cen_q <= 1'b0;
    end else begin
      ph_q  <= ph_next_o;
      cen_q <= (ph_next_o == CEN_PH);
      cep_q <= (ph_next_o == CEP_PH);
    end
  end

  assign ph_o  = ph_q;
  assign cep_o = cep_q;
  assign cen_o = cen_q;

endmodule

// File: rtl/sram_arbiter.sv
// Time-sliced arbiter sharing one asynchronous SRAM between a video fetcher and a CPU.
// Every action is registered on the edge entering its phase, so all SRAM pins are glitch-free.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned AW = 19
) (
  input  logic          clock,
  input  logic          reset,
  output logic          cep,
  output logic          cen,
  input  logic          cpu_mreq,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [15:0]   cpu_a,
  input  logic [7:0]    cpu_do,
  output logic [7:0]    cpu_di,
  input  logic [AW-17:0] bank,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_a,
  output logic          vid_ack,
  output logic [7:0]    vid_d,
  output logic [AW-1:0] sram_a,
  output logic [7:0]    sram_do,
  input  logic [7:0]    sram_di,
  output logic          sram_we
);

  phase_t     ph;
  phase_t     ph_next;
  cpu_op_e    cpu_op;
  arb_state_e state_q;

  logic [AW-1:0] sram_a_q;
  logic [7:0]    sram_do_q;
  logic          sram_we_q;
  logic          vid_ack_q;
  logic [7:0]    vid_d_q;
  logic [7:0]    cpu_di_q;

  slot_timer u_slot_timer (
    .clock     (clock),
    .reset     (reset),
    .ph_o      (ph),
    .ph_next_o (ph_next),
    .cep_o     (cep),
    .cen_o     (cen)
  );

  assign cpu_op = cpu_decode(cpu_mreq, cpu_rd, cpu_wr);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      sram_a_q  <= '0;
      sram_do_q <= '0;
      sram_we_q <= 1'b1;
      vid_ack_q <= 1'b0;
      vid_d_q   <= '0;
      cpu_di_q  <= 8'hFF;
    end else begin
      vid_ack_q <= 1'b0;
      sram_we_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          // Slot owners are only chosen on the edge entering their first phase.
          if (ph_next == VID_START) begin
            if (vid_req) begin
              sram_a_q <= vid_a;
              state_q  <= StVidRd;
            end
          end else if (ph_next == CPU_START) begin
            case (cpu_op)
              OpRead: begin
                sram_a_q <= {bank, cpu_a};
                state_q  <= StCpuRd;
              end
              OpWrite: begin
                sram_a_q  <= {bank, cpu_a};
                sram_do_q <= cpu_do;
                state_q   <= StCpuWr;
              end
              default: ;
            endcase
          end
        end
        StVidRd: begin
          // Data and ack land together so vid_d only moves in the ack cycle.
          if (ph_next == VID_LATCH) begin
            vid_d_q   <= sram_di;
            vid_ack_q <= 1'b1;
          end
          if (ph == VID_LATCH) state_q <= StIdle;
        end
        StCpuRd: begin
          if (ph == CPU_LATCH) begin
            cpu_di_q <= sram_di;
            state_q  <= StIdle;
          end
        end
        StCpuWr: begin
          // Address and data settle one phase before and hold one phase after the WE pulse.
          if (ph_next == WE_PH) sram_we_q <= 1'b0;
          if (ph == CPU_LATCH) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sram_a  = sram_a_q;
  assign sram_do = sram_do_q;
  assign sram_we = sram_we_q;
  assign vid_ack = vid_ack_q;
  assign vid_d   = vid_d_q;
  assign cpu_di  = cpu_di_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised bench for sram_arbiter: an SRAM device model plus a frame-level reference
// model (who owns each slot, what each read must return) checked every clock.
module tb_sram_arbiter;

  localparam int unsigned AW = 19;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cep, cen;
  logic          cpu_mreq, cpu_rd, cpu_wr;
  logic [15:0]   cpu_a;
  logic [7:0]    cpu_do, cpu_di;
  logic [2:0]    bank;
  logic          vid_req;
  logic [AW-1:0] vid_a;
  logic          vid_ack;
  logic [7:0]    vid_d;
  logic [AW-1:0] sram_a;
  logic [7:0]    sram_do;
  logic [7:0]    sram_di;
  logic          sram_we;

  sram_arbiter #(.AW(AW)) dut (
    .clock    (clock),
    .reset    (reset),
    .cep      (cep),
    .cen      (cen),
    .cpu_mreq (cpu_mreq),
    .cpu_rd   (cpu_rd),
    .cpu_wr   (cpu_wr),
    .cpu_a    (cpu_a),
    .cpu_do   (cpu_do),
    .cpu_di   (cpu_di),
    .bank     (bank),
    .vid_req  (vid_req),
    .vid_a    (vid_a),
    .vid_ack  (vid_ack),
    .vid_d    (vid_d),
    .sram_a   (sram_a),
    .sram_do  (sram_do),
    .sram_di  (sram_di),
    .sram_we  (sram_we)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // SRAM device: unwritten locations read a fixed address hash.
  logic [7:0] dev_mem [logic [AW-1:0]];
  logic [7:0] ref_mem [logic [AW-1:0]];

  function automatic logic [7:0] init_byte(logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]};
  endfunction

  function automatic logic [7:0] dev_read(logic [AW-1:0] a);
    if (dev_mem.exists(a)) return dev_mem[a];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] ref_read(logic [AW-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  always @(negedge clock) sram_di = dev_read(sram_a);
  always @(posedge clock) if (sram_we === 1'b0) dev_mem[sram_a] = sram_do;

  // Reference model state, one entry per frame role.
  int            ph_m;
  bit            vid_frame;
  logic [AW-1:0] vid_addr_m;
  int            cpu_kind;   // 0 none, 1 read, 2 write
  logic [AW-1:0] cpu_addr_m;
  logic [7:0]    cpu_data_m;
  logic [7:0]    exp_vid_d, exp_cpu_di;
  bit            vid_done;
  logic          obs_cen, obs_cep, obs_ack;
  int            we_low_cnt, ack_cnt;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic model_init();
    ph_m = 0; vid_frame = 0; cpu_kind = 0; vid_done = 0;
    exp_vid_d = 8'h00; exp_cpu_di = 8'hFF;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    dev_mem[a] = d;
    ref_mem[a] = d;
  endtask

  task automatic set_cpu(input logic m, input logic r, input logic w, input logic [2:0] b,
                         input logic [15:0] a, input logic [7:0] d);
    cpu_mreq = m; cpu_rd = r; cpu_wr = w; bank = b; cpu_a = a; cpu_do = d;
  endtask

  task automatic cpu_idle();
    cpu_mreq = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b1;
  endtask

  // One clock: compare outputs mid-cycle, then advance the model on the rising edge.
  task automatic tick();
    @(negedge clock);
    if (vid_frame && ph_m == 2) exp_vid_d = ref_read(vid_addr_m);
    obs_cen = cen; obs_cep = cep; obs_ack = vid_ack;
    if (sram_we === 1'b0) we_low_cnt++;
    if (vid_ack === 1'b1) ack_cnt++;
    check_eq("cen", 32'(cen), 32'(ph_m == 3));
    check_eq("cep", 32'(cep), 32'(ph_m == 7));
    check_eq("sram_we", 32'(sram_we), 32'(!(cpu_kind == 2 && ph_m == 5)));
    check_eq("vid_ack", 32'(vid_ack), 32'(vid_frame && ph_m == 2));
    check_eq("vid_d", 32'(vid_d), 32'(exp_vid_d));
    check_eq("cpu_di", 32'(cpu_di), 32'(exp_cpu_di));
    if (vid_frame && ph_m <= 2) check_eq("sram_a_vid", 32'(sram_a), 32'(vid_addr_m));
    if (cpu_kind != 0 && ph_m >= 4 && ph_m <= 6)
      check_eq("sram_a_cpu", 32'(sram_a), 32'(cpu_addr_m));
    if (cpu_kind == 2 && ph_m >= 5 && ph_m <= 6)
      check_eq("sram_do", 32'(sram_do), 32'(cpu_data_m));
    @(posedge clock);
    case (ph_m)
      7: begin vid_frame = vid_req; vid_addr_m = vid_a; end
      2: begin if (vid_frame) vid_done = 1; vid_frame = 0; end
      3: begin
        cpu_kind = 0;
        if (!cpu_mreq && !cpu_rd && cpu_wr) cpu_kind = 1;
        if (!cpu_mreq && !cpu_wr && cpu_rd) cpu_kind = 2;
        cpu_addr_m = {bank, cpu_a};
        cpu_data_m = cpu_do;
      end
      6: begin
        if (cpu_kind == 1) exp_cpu_di = ref_read(cpu_addr_m);
        if (cpu_kind == 2) ref_mem[cpu_addr_m] = cpu_data_m;
        cpu_kind = 0;
      end
      default: ;
    endcase
    ph_m = (ph_m + 1) % 8;
    #1;
  endtask

  task automatic check_reset_vals();
    @(negedge clock);
    check_eq("rst_cep", 32'(cep), 32'd0);
    check_eq("rst_cen", 32'(cen), 32'd0);
    check_eq("rst_vid_ack", 32'(vid_ack), 32'd0);
    check_eq("rst_sram_we", 32'(sram_we), 32'd1);
    check_eq("rst_sram_a", 32'(sram_a), 32'd0);
    check_eq("rst_sram_do", 32'(sram_do), 32'd0);
    check_eq("rst_vid_d", 32'(vid_d), 32'd0);
    check_eq("rst_cpu_di", 32'(cpu_di), 32'hFF);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    check_reset_vals();
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_init();
  endtask

  task automatic drive_rand();
    cpu_mreq = ($urandom_range(0, 3) == 0);
    cpu_rd   = 1'($urandom_range(0, 1));
    cpu_wr   = 1'($urandom_range(0, 1));
    bank     = 3'($urandom_range(0, 7));
    cpu_a    = 16'($urandom_range(0, 31));
    cpu_do   = 8'($urandom);
    if (vid_done) begin
      vid_req  = 1'b0;
      vid_done = 0;
    end else if (!vid_req && $urandom_range(0, 4) == 0) begin
      vid_req = 1'b1;
      vid_a   = {3'($urandom_range(0, 7)), 16'($urandom_range(0, 31))};
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first_cen, first_cep, lat, we_base;
    cpu_idle();
    bank = 3'd0; cpu_a = 16'h0; cpu_do = 8'h0;
    vid_req = 1'b0; vid_a = '0;
    we_low_cnt = 0; ack_cnt = 0;
    do_reset();

    // Free run: first enables after release.
    first_cen = 0; first_cep = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (obs_cen && first_cen == 0) first_cen = i;
      if (obs_cep && first_cep == 0) first_cep = i;
    end
    check_eq("first_cen", 32'(first_cen), 32'd4);
    check_eq("first_cep", 32'(first_cep), 32'd8);

    // CPU read.
    preload(19'h11234, 8'hA5);
    set_cpu(1'b0, 1'b0, 1'b1, 3'd1, 16'h1234, 8'h00);
    repeat (4) tick();
    cpu_idle();
    repeat (4) tick();
    check_eq("rd_cpu_di", 32'(cpu_di), 32'hA5);

    // CPU write: exactly one WE-low clock.
    we_base = we_low_cnt;
    set_cpu(1'b0, 1'b1, 1'b0, 3'd0, 16'h8000, 8'h5A);
    repeat (4) tick();
    cpu_idle();
    repeat (4) tick();
    check_eq("wr_mem", 32'(dev_read(19'h08000)), 32'h5A);
    check_eq("wr_we_cycles", 32'(we_low_cnt - we_base), 32'd1);

    // Video request raised at ph1.
    preload(19'h7FFFF, 8'h3C);
    tick();
    vid_req = 1'b1; vid_a = 19'h7FFFF; lat = 99;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (obs_ack) begin
        lat = n - 1;
        break;
      end
    end
    vid_req = 1'b0; vid_done = 0;
    check_eq("vid_latency", 32'(lat), 32'd9);
    check_eq("vid_d_3c", 32'(vid_d), 32'h3C);
    while (ph_m != 0) tick();

    // Video and CPU read in the same frame.
    preload(19'h20040, 8'h11);
    preload(19'h50040, 8'h22);
    vid_req = 1'b1; vid_a = 19'h20040;
    set_cpu(1'b0, 1'b0, 1'b1, 3'd5, 16'h0040, 8'h00);
    repeat (11) tick();
    vid_req = 1'b0; vid_done = 0;
    tick();
    cpu_idle();
    while (ph_m != 0) tick();
    check_eq("both_vid_d", 32'(vid_d), 32'h11);
    check_eq("both_cpu_di", 32'(cpu_di), 32'h22);

    // Request withdrawn before the video slot gets no access.
    ack_cnt = 0;
    repeat (4) tick();
    vid_req = 1'b1; vid_a = 19'h00123;
    repeat (2) tick();
    vid_req = 1'b0;
    repeat (10) tick();
    check_eq("dropped_req_acks", 32'(ack_cnt), 32'd0);

    // Randomised traffic.
    for (int f = 0; f < 150 * 8; f++) begin
      drive_rand();
      tick();
    end
    cpu_idle();
    vid_req = 1'b0; vid_done = 0;
    while (ph_m != 0) tick();

    // Reset during the WE pulse of a write.
    set_cpu(1'b0, 1'b1, 1'b0, 3'd6, 16'h0077, 8'hC3);
    repeat (4) tick();
    cpu_idle();
    tick();
    @(negedge clock);
    check_eq("we_ph5", 32'(sram_we), 32'd0);
    do_reset();
    ref_mem[{3'd6, 16'h0077}] = 8'hC3;
    repeat (16) tick();

    // Reset during a video read: no late ack.
    vid_req = 1'b1; vid_a = 19'h30010;
    repeat (9) tick();
    vid_req = 1'b0;
    do_reset();
    ack_cnt = 0;
    repeat (16) tick();
    check_eq("no_late_ack", 32'(ack_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
